// File: rtl/fde_unit.sv
// Fetch/decode/execute front end of a multi-cycle RV32I core.
// Each phase updates its own register bank on the edge that ends it.
module fde_unit #(
    parameter int IMEM_AW = 10
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [2:0]         state,
    input  logic [31:0]        pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [4:0]         rs1_a,
    output logic [4:0]         rs2_a,
    output logic [4:0]         rd_a,
    input  logic [31:0]        rs1_v,
    input  logic [31:0]        rs2_v,
    output logic [31:0]        imm,
    output logic [2:0]         funct3,
    output logic               is_load,
    output logic               is_store,
    output logic               illegal,
    output logic [31:0]        result,
    output logic               mem_read_enabled,
    output logic               mem_write_enabled,
    output logic [31:0]        mem_target,
    output logic               reg_write_enabled,
    output logic [4:0]         reg_write_dest,
    output logic               is_jump_enabled,
    output logic [31:0]        jump_dest
);

    typedef enum logic [3:0] {
        K_NONE, K_LUI, K_AUIPC, K_JAL, K_JALR,
        K_BR, K_LOAD, K_STORE, K_ALUI, K_ALU
    } kind_t;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;

    logic [31:0] ir, pc_instr, imm_d;
    kind_t       kind_q, kind_d;
    logic        alt_q, alt_d;
    logic [6:0]  op, f7;
    logic [2:0]  f3;

    assign imem_addr = pc[IMEM_AW+1:2];
    assign op = ir[6:0];
    assign f3 = ir[14:12];
    assign f7 = ir[31:25];

    always_comb begin
        kind_d = K_NONE;
        imm_d  = '0;
        alt_d  = 1'b0;
        case (op)
            7'b0110111: begin
                kind_d = K_LUI;
                imm_d  = {ir[31:12], 12'b0};
            end
            7'b0010111: begin
                kind_d = K_AUIPC;
                imm_d  = {ir[31:12], 12'b0};
            end
            7'b1101111: begin
                kind_d = K_JAL;
                imm_d  = {{11{ir[31]}}, ir[31], ir[19:12],
                          ir[20], ir[30:21], 1'b0};
            end
            7'b1100111: begin
                imm_d = {{20{ir[31]}}, ir[31:20]};
                if (f3 == 3'd0) kind_d = K_JALR;
            end
            7'b1100011: begin
                imm_d = {{19{ir[31]}}, ir[31], ir[7],
                         ir[30:25], ir[11:8], 1'b0};
                if (f3 != 3'd2 && f3 != 3'd3) kind_d = K_BR;
            end
            7'b0000011: begin
                imm_d = {{20{ir[31]}}, ir[31:20]};
                if (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7)
                    kind_d = K_LOAD;
            end
            7'b0100011: begin
                imm_d = {{20{ir[31]}}, ir[31:25], ir[11:7]};
                if (f3 <= 3'd2) kind_d = K_STORE;
            end
            7'b0010011: begin
                imm_d = {{20{ir[31]}}, ir[31:20]};
                // shift-immediates reuse imm[11:5] as a funct7
                if (f3 == 3'd1) begin
                    if (f7 == 7'h00) kind_d = K_ALUI;
                end else if (f3 == 3'd5) begin
                    if (f7 == 7'h00 || f7 == 7'h20) kind_d = K_ALUI;
                    alt_d = ir[30];
                end else begin
                    kind_d = K_ALUI;
                end
            end
            7'b0110011: begin
                if (f7 == 7'h00 ||
                    (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                    kind_d = K_ALU;
                    alt_d  = ir[30];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ir <= '0;
        end else if (state == ST_FETCH) begin
            ir <= imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rs1_a    <= '0;
            rs2_a    <= '0;
            rd_a     <= '0;
            imm      <= '0;
            funct3   <= '0;
            is_load  <= 1'b0;
            is_store <= 1'b0;
            illegal  <= 1'b0;
            kind_q   <= K_NONE;
            alt_q    <= 1'b0;
            pc_instr <= '0;
        end else if (state == ST_DECODE) begin
            rs1_a    <= ir[19:15];
            rs2_a    <= ir[24:20];
            rd_a     <= ir[11:7];
            imm      <= imm_d;
            funct3   <= f3;
            is_load  <= (kind_d == K_LOAD);
            is_store <= (kind_d == K_STORE);
            illegal  <= (kind_d == K_NONE);
            kind_q   <= kind_d;
            alt_q    <= alt_d;
            pc_instr <= pc;
        end
    end

    logic [31:0] opb, sum, pc_imm, alu_r, res_d, mt_d, jd_d;
    logic [4:0]  sh;
    logic        take, wr, mre_d, mwe_d, jmp_d;

    assign opb    = (kind_q == K_ALU) ? rs2_v : imm;
    assign sh     = opb[4:0];
    assign sum    = rs1_v + imm;
    assign pc_imm = pc_instr + imm;

    always_comb begin
        alu_r = '0;
        case (funct3)
            3'd0: alu_r = alt_q ? rs1_v - opb : rs1_v + opb;
            3'd1: alu_r = rs1_v << sh;
            3'd2: alu_r = {31'd0, $signed(rs1_v) < $signed(opb)};
            3'd3: alu_r = {31'd0, rs1_v < opb};
            3'd4: alu_r = rs1_v ^ opb;
            3'd5: alu_r = alt_q ? $unsigned($signed(rs1_v) >>> sh)
                                : rs1_v >> sh;
            3'd6: alu_r = rs1_v | opb;
            default: alu_r = rs1_v & opb;
        endcase
    end

    always_comb begin
        take = 1'b0;
        case (funct3)
            3'd0: take = (rs1_v == rs2_v);
            3'd1: take = (rs1_v != rs2_v);
            3'd4: take = ($signed(rs1_v) < $signed(rs2_v));
            3'd5: take = ($signed(rs1_v) >= $signed(rs2_v));
            3'd6: take = (rs1_v < rs2_v);
            3'd7: take = (rs1_v >= rs2_v);
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        res_d = '0;
        mt_d  = '0;
        jd_d  = '0;
        wr    = 1'b0;
        mre_d = 1'b0;
        mwe_d = 1'b0;
        jmp_d = 1'b0;
        case (kind_q)
            K_LUI:   begin res_d = imm;    wr = 1'b1; end
            K_AUIPC: begin res_d = pc_imm; wr = 1'b1; end
            K_JAL: begin
                res_d = pc_instr + 32'd4;
                jmp_d = 1'b1;
                jd_d  = pc_imm;
                wr    = 1'b1;
            end
            K_JALR: begin
                res_d = pc_instr + 32'd4;
                jmp_d = 1'b1;
                jd_d  = {sum[31:1], 1'b0};
                wr    = 1'b1;
            end
            K_BR: begin
                jmp_d = take;
                jd_d  = take ? pc_imm : 32'd0;
            end
            K_LOAD: begin
                res_d = sum;
                mt_d  = sum;
                mre_d = 1'b1;
                wr    = 1'b1;
            end
            K_STORE: begin
                res_d = sum;
                mt_d  = sum;
                mwe_d = 1'b1;
            end
            K_ALUI, K_ALU: begin res_d = alu_r; wr = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            result            <= '0;
            mem_read_enabled  <= 1'b0;
            mem_write_enabled <= 1'b0;
            mem_target        <= '0;
            reg_write_enabled <= 1'b0;
            reg_write_dest    <= '0;
            is_jump_enabled   <= 1'b0;
            jump_dest         <= '0;
        end else if (state == ST_EXEC) begin
            result            <= res_d;
            mem_read_enabled  <= mre_d;
            mem_write_enabled <= mwe_d;
            mem_target        <= mt_d;
            reg_write_enabled <= wr && (rd_a != 5'd0);
            reg_write_dest    <= rd_a;
            is_jump_enabled   <= jmp_d;
            jump_dest         <= jd_d;
        end
    end

endmodule

// File: tb/tb_fde_unit.sv
// Bench for fde_unit: directed RV32I cases, reset checks and random
// instructions scored against an instruction-level reference model.
module tb_fde_unit;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rstn;
    logic [2:0]    state;
    logic [31:0]   pc, imem_rdata, rs1_v, rs2_v;
    logic [AW-1:0] imem_addr;
    logic [4:0]    rs1_a, rs2_a, rd_a, reg_write_dest;
    logic [31:0]   imm, result, mem_target, jump_dest;
    logic [2:0]    funct3;
    logic          is_load, is_store, illegal;
    logic          mem_read_enabled, mem_write_enabled;
    logic          reg_write_enabled, is_jump_enabled;

    fde_unit #(.IMEM_AW(AW)) dut (
        .clk(clk), .rstn(rstn), .state(state), .pc(pc),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .rs1_a(rs1_a), .rs2_a(rs2_a), .rd_a(rd_a),
        .rs1_v(rs1_v), .rs2_v(rs2_v), .imm(imm), .funct3(funct3),
        .is_load(is_load), .is_store(is_store), .illegal(illegal),
        .result(result), .mem_read_enabled(mem_read_enabled),
        .mem_write_enabled(mem_write_enabled), .mem_target(mem_target),
        .reg_write_enabled(reg_write_enabled),
        .reg_write_dest(reg_write_dest),
        .is_jump_enabled(is_jump_enabled), .jump_dest(jump_dest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1_a, rs2_a, rd_a;
        logic [31:0] imm;
        logic [2:0]  funct3;
        logic        is_load, is_store, illegal;
        logic [31:0] result, mtgt, jdst;
        logic        mre, mwe, rwe, jmp;
        logic        imm_chk, res_chk, mt_chk;
    } exp_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic chk_phase = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] alu(input logic [2:0] f,
                                        input logic alt,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        int unsigned s = b % 32;
        case (f)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << s;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? $unsigned($signed(a) >>> s) : a >> s;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] i,
                                   input logic [31:0] p,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t e;
        logic [6:0] op = i[6:0];
        logic [6:0] f7 = i[31:25];
        logic [2:0] f3 = i[14:12];
        logic [31:0] im_i = {{20{i[31]}}, i[31:20]};
        logic [31:0] im_s = {{20{i[31]}}, i[31:25], i[11:7]};
        logic [31:0] im_b = {{19{i[31]}}, i[31], i[7], i[30:25],
                             i[11:8], 1'b0};
        logic [31:0] im_u = {i[31:12], 12'b0};
        logic [31:0] im_j = {{11{i[31]}}, i[31], i[19:12], i[20],
                             i[30:21], 1'b0};
        logic ok = 1'b0;
        logic wr = 1'b0;
        logic t;
        e = '{rs1_a: i[19:15], rs2_a: i[24:20], rd_a: i[11:7],
              imm: 0, funct3: f3, is_load: 0, is_store: 0,
              illegal: 1, result: 0, mtgt: 0, jdst: 0,
              mre: 0, mwe: 0, rwe: 0, jmp: 0,
              imm_chk: 0, res_chk: 0, mt_chk: 0};
        if (op == 7'h37) begin
            ok = 1; wr = 1; e.imm = im_u; e.result = im_u;
        end else if (op == 7'h17) begin
            ok = 1; wr = 1; e.imm = im_u; e.result = p + im_u;
        end else if (op == 7'h6f) begin
            ok = 1; wr = 1; e.imm = im_j; e.result = p + 4;
            e.jmp = 1; e.jdst = p + im_j;
        end else if (op == 7'h67 && f3 == 0) begin
            ok = 1; wr = 1; e.imm = im_i; e.result = p + 4;
            e.jmp = 1; e.jdst = (a + im_i) & ~32'd1;
        end else if (op == 7'h63 && f3 != 2 && f3 != 3) begin
            ok = 1; e.imm = im_b;
            case (f3)
                0: t = a == b;
                1: t = a != b;
                4: t = $signed(a) < $signed(b);
                5: t = $signed(a) >= $signed(b);
                6: t = a < b;
                default: t = a >= b;
            endcase
            e.jmp = t; e.jdst = t ? p + im_b : 0;
        end else if (op == 7'h03 && f3 inside {0, 1, 2, 4, 5}) begin
            ok = 1; wr = 1; e.imm = im_i; e.is_load = 1; e.mre = 1;
            e.mtgt = a + im_i; e.result = a + im_i;
        end else if (op == 7'h23 && f3 <= 2) begin
            ok = 1; e.imm = im_s; e.is_store = 1; e.mwe = 1;
            e.mtgt = a + im_s; e.result = a + im_s;
        end else if (op == 7'h13 &&
                     !(f3 == 1 && f7 != 0) &&
                     !(f3 == 5 && f7 != 0 && f7 != 7'h20)) begin
            ok = 1; wr = 1; e.imm = im_i;
            e.result = alu(f3, f3 == 5 && f7 == 7'h20, a, im_i);
        end else if (op == 7'h33 &&
                     (f7 == 0 || (f7 == 7'h20 && f3 inside {0, 5}))) begin
            ok = 1; wr = 1;
            e.result = alu(f3, f7 == 7'h20, a, b);
        end
        if (ok) begin
            e.illegal = 0;
            e.imm_chk = (op != 7'h33);
            e.res_chk = (op != 7'h63);
            e.mt_chk  = e.mre | e.mwe;
            e.rwe     = wr && (i[11:7] != 0);
        end
        return e;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_phase) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("rs1_a", 32'(rs1_a), 32'(e.rs1_a));
                    chk("rs2_a", 32'(rs2_a), 32'(e.rs2_a));
                    chk("rd_a", 32'(rd_a), 32'(e.rd_a));
                    chk("funct3", 32'(funct3), 32'(e.funct3));
                    chk("class", {is_load, is_store, illegal},
                        {e.is_load, e.is_store, e.illegal});
                    if (e.imm_chk) chk("imm", imm, e.imm);
                    if (e.res_chk) chk("result", result, e.result);
                    if (e.mt_chk) chk("mem_target", mem_target, e.mtgt);
                    chk("mem_en", {mem_read_enabled, mem_write_enabled},
                        {e.mre, e.mwe});
                    chk("rwe", 32'(reg_write_enabled), 32'(e.rwe));
                    chk("rwd", 32'(reg_write_dest), 32'(e.rd_a));
                    chk("jmp", 32'(is_jump_enabled), 32'(e.jmp));
                    chk("jdst", jump_dest, e.jdst);
                end
            end
        end
    end

    task automatic step(input logic [2:0] s);
        state = s;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [31:0] ins, input logic [31:0] pcv,
                       input logic [31:0] a, input logic [31:0] b);
        pc = pcv; imem_rdata = ins;
        rs1_v = $urandom; rs2_v = $urandom;
        #1;
        chk("imem_addr", 32'(imem_addr), (pcv >> 2) % (32'd1 << AW));
        step(3'd0);
        imem_rdata = $urandom;
        step(3'd1);
        pc = $urandom; rs1_v = a; rs2_v = b;
        sb.push_back(model(ins, pcv, a, b));
        step(3'd2);
        rs1_v = $urandom; rs2_v = $urandom;
        imem_rdata = $urandom; pc = $urandom;
        step(3'd3);
        if ($urandom_range(0, 3) == 0) step(3'($urandom_range(5, 7)));
        chk_phase = 1'b1;
        step(3'd4);
        chk_phase = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [6:0]  ops[9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63,
                                7'h03, 7'h23, 7'h13, 7'h33};
        logic [31:0] ins, a, b;
        int          k;
        rstn = 1'b0; state = 3'd4; pc = '0;
        imem_rdata = '0; rs1_v = '0; rs2_v = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", result, 0);
        chk("rst_imm", imm, 0);
        chk("rst_flags", {illegal, mem_read_enabled, mem_write_enabled,
                          reg_write_enabled, is_jump_enabled}, 0);
        rstn = 1'b1;
        step(3'd4);

        run(32'h0050_0093, 32'h0, 32'h0, $urandom);
        chk("addi_result", result, 5);
        chk("addi_rwe", 32'(reg_write_enabled), 1);
        chk("addi_rwd", 32'(reg_write_dest), 1);
        run(32'h0020_8463, 32'h10, 32'd7, 32'd7);
        chk("beq_t_jmp", 32'(is_jump_enabled), 1);
        chk("beq_t_dst", jump_dest, 32'h18);
        run(32'h0020_8463, 32'h10, 32'd7, 32'd8);
        chk("beq_nt_jmp", 32'(is_jump_enabled), 0);
        run(32'h0041_2183, 32'h20, 32'h100, $urandom);
        chk("lw_tgt", mem_target, 32'h104);
        chk("lw_f3", 32'(funct3), 2);
        chk("lw_mre", 32'(mem_read_enabled), 1);
        run(32'h0002_80E7, 32'h40, 32'h203, $urandom);
        chk("jalr_dst", jump_dest, 32'h202);
        chk("jalr_res", result, 32'h44);
        run(32'h4020_D1B3, 32'h50, 32'h8000_0000, 32'h24);
        chk("sra_res", result, 32'hF800_0000);
        run(32'h0000_007F, 32'h60, $urandom, $urandom);
        chk("ill_flag", 32'(illegal), 1);
        chk("ill_en", {mem_read_enabled, mem_write_enabled,
                       reg_write_enabled, is_jump_enabled}, 0);

        // reset pulse in the middle of an EXEC cycle
        run(32'h4020_D1B3, 32'h50, 32'h8000_0000, 32'h24);
        pc = 32'h70; imem_rdata = 32'h0050_0093;
        step(3'd0);
        step(3'd1);
        rs1_v = 32'h1234; state = 3'd2;
        #2 rstn = 1'b0;
        #1;
        chk("rx_result", result, 0);
        chk("rx_imm", imm, 0);
        chk("rx_regs", {rs1_a, rs2_a, rd_a, reg_write_dest}, 0);
        chk("rx_flags", {illegal, is_load, is_store, mem_read_enabled,
                         mem_write_enabled, reg_write_enabled,
                         is_jump_enabled}, 0);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("rx_post_result", result, 0);
        chk("rx_post_rwe", 32'(reg_write_enabled), 0);
        step(3'd3);
        run(32'h0050_0093, 32'h80, 32'd10, $urandom);
        chk("rx_resume", result, 15);

        repeat (400) begin
            k = $urandom_range(0, 9);
            ins = $urandom;
            if (k < 9) begin
                ins[6:0] = ops[k];
                if ((k == 7 || k == 8) && $urandom_range(0, 3) != 0)
                    ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            end
            a = pick();
            b = ($urandom_range(0, 3) == 0) ? a : pick();
            run(ins, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, a, b);
        end

        step(3'd4);
        chk("sb_drain", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fde_unit.md
FDE_UNIT -- requirements
Module: fde_unit

Interface
REQ-001 SHALL have parameter IMEM_AW, default 10: instruction-memory word-address width.
REQ-002 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn  in  1: reset, asynchronous and active-low.
REQ-004 SHALL have port state  in  3: core phase (FETCH=0, DECODE=1, EXEC=2, MEM=3, WRITE=4).
REQ-005 SHALL have port pc  in  32: address of the current instruction.
REQ-006 SHALL have port imem_addr  out  IMEM_AW: instruction word address.
REQ-007 SHALL have port imem_rdata  in  32: combinational instruction-memory read data.
REQ-008 SHALL have ports rs1_a, rs2_a, rd_a  out  5 each: decoded register addresses.
REQ-009 SHALL have ports rs1_v, rs2_v  in  32 each: register-file read values for rs1_a and rs2_a.
REQ-010 SHALL have port imm  out  32: sign-extended decoded immediate.
REQ-011 SHALL have port funct3  out  3: decoded funct3, used by MEM for load/store width and sign.
REQ-012 SHALL have ports is_load, is_store, illegal  out  1 each: decoded instruction class.
REQ-013 SHALL have port result  out  32: execute result.
REQ-014 SHALL have ports mem_read_enabled, mem_write_enabled  out  1 each; mem_target  out  32: load/store byte address.
REQ-015 SHALL have ports reg_write_enabled  out  1; reg_write_dest  out  5.
REQ-016 SHALL have ports is_jump_enabled  out  1; jump_dest  out  32.

Function
REQ-017 SHALL drive imem_addr = pc[IMEM_AW+1:2] combinationally.
REQ-018 SHALL latch imem_rdata into an instruction register on the clock edge that ends a cycle with state==FETCH; otherwise the register holds.
REQ-019 SHALL decode the instruction register on the edge that ends state==DECODE.
- Registered outputs: rs1_a, rs2_a, rd_a, imm, funct3, class flags.
- Also latches pc as pc_instr.
REQ-020 SHALL decode RV32I: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP.
- Any other opcode/funct combination SHALL set illegal=1 and produce no write, memory access or jump.
REQ-021 SHALL form imm per RISC-V type:
- I, S, B, U, J formats.
- Sign-extended from instruction bit 31; B/J immediates have bit 0 = 0; U immediate = {instr[31:12], 12'b0}.
REQ-022 SHALL register all execute outputs on the edge that ends state==EXEC, using rs1_v and rs2_v as sampled in that cycle.
REQ-023 SHALL hold all execute outputs stable during MEM and WRITE, and until the next EXEC edge.
REQ-024 SHALL compute result as follows:
- ALU ops: 32-bit wrap-around arithmetic.
- Shift amount: low 5 bits of rs2_v or imm; SRA/SRAI arithmetic.
- SLT/SLTI signed, SLTU/SLTIU unsigned.
- LUI: imm. AUIPC: pc_instr+imm. JAL/JALR: pc_instr+4.
- Loads/stores: rs1_v+imm.
REQ-025 SHALL drive mem_target = rs1_v+imm for loads and stores, and mem_read_enabled/mem_write_enabled = is_load/is_store.
REQ-026 SHALL drive jump outputs as follows:
- JAL: is_jump_enabled=1, jump_dest=pc_instr+imm.
- JALR: is_jump_enabled=1, jump_dest=(rs1_v+imm) with bit 0 cleared.
- Branches: is_jump_enabled=1 only when the condition holds, jump_dest=pc_instr+imm.
- Otherwise is_jump_enabled=0 and jump_dest=0.
REQ-027 SHALL set reg_write_enabled=1 for LUI, AUIPC, JAL, JALR, loads, OP-IMM and OP only when rd!=0; otherwise 0.
REQ-028 SHALL set reg_write_dest=rd_a.
REQ-029 SHALL NOT check address alignment; misaligned handling belongs to the MEM stage.
REQ-030 SHALL update nothing when state is MEM, WRITE or any undefined value.

Reset
REQ-031 SHALL, while rstn=0, asynchronously clear the instruction register, pc_instr and every registered output to 0.
- illegal, mem enables, reg_write_enabled and is_jump_enabled SHALL be 0.
REQ-032 SHALL resume at the next FETCH edge after rstn returns high; reset mid-operation discards the in-flight instruction.

Verification
REQ-033 ADDI x1,x0,5 (0x00500093), rs1_v=0 through FETCH/DECODE/EXEC -> result=5, reg_write_enabled=1, reg_write_dest=1, is_jump_enabled=0.
REQ-034 BEQ x1,x2,8 (0x00208463), pc=0x10:
- rs1_v=rs2_v=7 -> is_jump_enabled=1, jump_dest=0x18.
- rs2_v=8 -> is_jump_enabled=0.
REQ-035 LW x3,4(x2) (0x00412183), rs1_v=0x100 -> mem_read_enabled=1, mem_target=0x104, funct3=2, reg_write_dest=3.
REQ-036 JALR x1,0(x5) (0x000280E7), pc=0x40, rs1_v=0x203 -> jump_dest=0x202, result=0x44, reg_write_enabled=1.
REQ-037 SRA x3,x1,x2 (0x4020D1B3), rs1_v=0x80000000, rs2_v=0x24 -> result=0xF8000000.
REQ-038 Opcode 0x0000007F -> illegal=1, no enables.
REQ-039 rstn pulsed low mid-EXEC -> all outputs 0 immediately.
